// File: rtl/drive_param_bank.sv
// Per-channel cycle/duty/phase store: CPU-written staging bank, serial scale/clamp
// scan into a shadow bank on UPDATE, then an atomic commit to the active bank.
module drive_param_bank #(
  parameter int WIDTH         = 13,
  parameter int TRANS_NUM     = 249,
  parameter int MOD_WIDTH     = 8,
  parameter int DEFAULT_CYCLE = 5000,
  localparam int AW           = $clog2(TRANS_NUM)
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                WE,
  input  logic [AW-1:0]                       ADDR,
  input  logic [1:0]                          SEL,
  input  logic [WIDTH-1:0]                    WDATA,
  input  logic [MOD_WIDTH-1:0]                MOD,
  input  logic                                UPDATE,
  output logic [0:TRANS_NUM-1][WIDTH-1:0]     CYCLE,
  output logic [0:TRANS_NUM-1][WIDTH-1:0]     DUTY,
  output logic [0:TRANS_NUM-1][WIDTH-1:0]     PHASE,
  output logic                                BUSY,
  output logic                                OUT_VALID,
  output logic                                MISSED,
  output logic [1:0]                          DBG_STATE
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_COMMIT} state_t;

  localparam int PW = WIDTH + MOD_WIDTH + 1;
  localparam logic [AW:0]       N_LIM   = (AW+1)'(TRANS_NUM);
  localparam logic [AW-1:0]     LAST    = AW'(TRANS_NUM - 1);
  localparam logic [WIDTH-1:0]  DEF_CYC = WIDTH'(DEFAULT_CYCLE);

  state_t r_state, w_next_state;
  logic [AW-1:0]        r_idx;
  logic                 r_drain_cnt;
  logic [MOD_WIDTH-1:0] r_mod_l;

  logic [WIDTH-1:0] r_stg_c [0:TRANS_NUM-1];
  logic [WIDTH-1:0] r_stg_d [0:TRANS_NUM-1];
  logic [WIDTH-1:0] r_stg_p [0:TRANS_NUM-1];
  logic [WIDTH-1:0] r_shd_c [0:TRANS_NUM-1];
  logic [WIDTH-1:0] r_shd_d [0:TRANS_NUM-1];
  logic [WIDTH-1:0] r_shd_p [0:TRANS_NUM-1];

  logic             r_s1_valid, r_s2_valid;
  logic [AW-1:0]    r_s1_idx, r_s2_idx;
  logic [WIDTH-1:0] r_s1_c, r_s1_p;
  logic [WIDTH:0]   r_s1_ds;
  logic [WIDTH-1:0] r_s2_c, r_s2_d, r_s2_p;

  logic [MOD_WIDTH:0] w_mod_p1;
  logic [PW-1:0]      w_prod;
  logic [WIDTH:0]     w_ds;

  assign BUSY      = (r_state != S_IDLE);
  assign DBG_STATE = r_state;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (UPDATE) w_next_state = S_SCAN;
      S_SCAN:   if (r_idx == LAST) w_next_state = S_DRAIN;
      S_DRAIN:  if (r_drain_cnt) w_next_state = S_COMMIT;
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // UPDATE outside IDLE (including the COMMIT edge) is dropped and remembered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx       <= '0;
      r_drain_cnt <= 1'b0;
      r_mod_l     <= '0;
      MISSED      <= 1'b0;
      OUT_VALID   <= 1'b0;
    end else begin
      OUT_VALID <= (r_state == S_COMMIT);
      if (UPDATE && r_state != S_IDLE) MISSED <= 1'b1;
      case (r_state)
        S_IDLE: if (UPDATE) begin
          r_mod_l <= MOD;
          r_idx   <= '0;
        end
        S_SCAN: begin
          r_drain_cnt <= 1'b0;
          if (r_idx != LAST) r_idx <= r_idx + 1'b1;
        end
        S_DRAIN: r_drain_cnt <= ~r_drain_cnt;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        r_stg_c[i] <= DEF_CYC;
        r_stg_d[i] <= '0;
        r_stg_p[i] <= '0;
      end
    end else if (WE && ({1'b0, ADDR} < N_LIM)) begin
      case (SEL)
        2'd0:    r_stg_c[ADDR] <= WDATA;
        2'd1:    r_stg_d[ADDR] <= WDATA;
        2'd2:    r_stg_p[ADDR] <= WDATA;
        default: ;
      endcase
    end
  end

  // d*(mod+1)>>MOD_WIDTH never exceeds d, so full-scale modulation is exact
  always_comb begin
    w_mod_p1 = {1'b0, r_mod_l} + {{MOD_WIDTH{1'b0}}, 1'b1};
    w_prod   = {{(MOD_WIDTH+1){1'b0}}, r_stg_d[r_idx]} * {{WIDTH{1'b0}}, w_mod_p1};
    w_ds     = (WIDTH+1)'(w_prod >> MOD_WIDTH);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s2_idx   <= '0;
      r_s1_c     <= '0;
      r_s1_p     <= '0;
      r_s1_ds    <= '0;
      r_s2_c     <= '0;
      r_s2_d     <= '0;
      r_s2_p     <= '0;
    end else begin
      r_s1_valid <= (r_state == S_SCAN);
      r_s1_idx   <= r_idx;
      r_s1_c     <= r_stg_c[r_idx];
      r_s1_p     <= r_stg_p[r_idx];
      r_s1_ds    <= w_ds;
      r_s2_valid <= r_s1_valid;
      r_s2_idx   <= r_s1_idx;
      r_s2_c     <= r_s1_c;
      if (r_s1_c == '0) begin
        r_s2_d <= '0;
        r_s2_p <= '0;
      end else begin
        r_s2_d <= (r_s1_ds > {1'b0, r_s1_c}) ? r_s1_c : r_s1_ds[WIDTH-1:0];
        r_s2_p <= (r_s1_p >= r_s1_c) ? '0 : r_s1_p;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        r_shd_c[i] <= DEF_CYC;
        r_shd_d[i] <= '0;
        r_shd_p[i] <= '0;
      end
    end else if (r_s2_valid) begin
      r_shd_c[r_s2_idx] <= r_s2_c;
      r_shd_d[r_s2_idx] <= r_s2_d;
      r_shd_p[r_s2_idx] <= r_s2_p;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        CYCLE[i] <= DEF_CYC;
        DUTY[i]  <= '0;
        PHASE[i] <= '0;
      end
    end else if (r_state == S_COMMIT) begin
      for (int i = 0; i < TRANS_NUM; i++) begin
        CYCLE[i] <= r_shd_c[i];
        DUTY[i]  <= r_shd_d[i];
        PHASE[i] <= r_shd_p[i];
      end
    end
  end

endmodule

// File: tb/tb_drive_param_bank.sv
// Bench for drive_param_bank: drives staging writes and UPDATE scans, compares the
// active bank and status outputs with a channel-level reference model.
module tb_drive_param_bank;
  localparam int W  = 13;
  localparam int N  = 249;
  localparam int MW = 8;
  localparam int DC = 5000;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst, we, upd;
  logic [AW-1:0] addr;
  logic [1:0] sel;
  logic [W-1:0] wdata;
  logic [MW-1:0] mod;
  logic [0:N-1][W-1:0] cyc, duty, phase;
  logic busy, ov, missed;
  logic [1:0] dbg_state;

  drive_param_bank #(.WIDTH(W), .TRANS_NUM(N), .MOD_WIDTH(MW), .DEFAULT_CYCLE(DC)) dut (
    .CLK(clk), .RESET(rst), .WE(we), .ADDR(addr), .SEL(sel), .WDATA(wdata),
    .MOD(mod), .UPDATE(upd), .CYCLE(cyc), .DUTY(duty), .PHASE(phase),
    .BUSY(busy), .OUT_VALID(ov), .MISSED(missed), .DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: staging, active, and per-channel snapshot taken when the scan reads it
  int m_c[N], m_d[N], m_p[N];
  int a_c[N], a_d[N], a_p[N];
  int s_c[N], s_d[N], s_p[N];
  int ov_edge, ov_count, busy_bad, bank_bad, rst_mm;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_c[i] = DC; m_d[i] = 0; m_p[i] = 0;
      a_c[i] = DC; a_d[i] = 0; a_p[i] = 0;
    end
  endtask

  task automatic model_write(input int a, input int s, input int d);
    if (a < N) begin
      if (s == 0) m_c[a] = d;
      else if (s == 1) m_d[a] = d;
      else if (s == 2) m_p[a] = d;
    end
  endtask

  function automatic int bank_mm();
    int n = 0;
    for (int k = 0; k < N; k++)
      if (cyc[k] !== W'(a_c[k]) || duty[k] !== W'(a_d[k]) || phase[k] !== W'(a_p[k])) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_write(input int a, input int s, input int d);
    we = 1'b1; addr = AW'(a); sel = 2'(s); wdata = W'(d);
    tick();
    we = 1'b0;
    model_write(a, s, d);
  endtask

  // UPDATE at edge j=0; optional write, second UPDATE or RESET before edge j
  task automatic run_update(input int m, input int wr_j, input int wr_a, input int wr_s,
                            input int wr_d, input int upd2_j, input int rst_j);
    bit aborted = 1'b0;
    ov_edge = -1; ov_count = 0; busy_bad = 0; bank_bad = 0; rst_mm = -1;
    upd = 1'b1; mod = MW'(m);
    tick();
    upd = 1'b0;
    for (int j = 1; j <= N + 4; j++) begin
      if (j == wr_j) begin we = 1'b1; addr = AW'(wr_a); sel = 2'(wr_s); wdata = W'(wr_d); end
      if (j == upd2_j) upd = 1'b1;
      if (j == rst_j) rst = 1'b1;
      if (!aborted && j - 1 < N) begin
        s_c[j-1] = m_c[j-1]; s_d[j-1] = m_d[j-1]; s_p[j-1] = m_p[j-1];
      end
      tick();
      we = 1'b0; upd = 1'b0;
      if (j == rst_j) begin
        rst = 1'b0;
        model_reset();
        aborted = 1'b1;
        rst_mm = bank_mm();
      end else if (j == wr_j) begin
        model_write(wr_a, wr_s, wr_d);
      end
      if (j == N + 3 && !aborted) begin
        for (int k = 0; k < N; k++) begin
          int ds;
          ds = (s_d[k] * (m + 1)) >> MW;
          a_c[k] = s_c[k];
          if (s_c[k] == 0) begin a_d[k] = 0; a_p[k] = 0; end
          else begin
            a_d[k] = (ds < s_c[k]) ? ds : s_c[k];
            a_p[k] = (s_p[k] >= s_c[k]) ? 0 : s_p[k];
          end
        end
      end
      if (ov === 1'b1) begin ov_count++; if (ov_edge < 0) ov_edge = j; end
      if (busy !== ((!aborted && j < N + 3) ? 1'b1 : 1'b0)) busy_bad++;
      if (bank_mm() != 0) bank_bad++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov); end
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL reset_missed: got %b want 0", missed); end
    checks++; if (cyc[0] !== W'(5000)) begin errors++; $display("FAIL reset_cycle0: got %0d want 5000", cyc[0]); end
    checks++; if (bank_mm() != 0) begin errors++; $display("FAIL reset_bank: %0d channels differ, want 0", bank_mm()); end
  endtask

  task automatic test_default_update();
    run_update(255, -1, 0, 0, 0, -1, -1);
    checks++; if (ov_edge != N + 3) begin errors++; $display("FAIL default_latency: got %0d want %0d", ov_edge, N + 3); end
    checks++; if (ov_count != 1) begin errors++; $display("FAIL default_ov_count: got %0d want 1", ov_count); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL default_busy: %0d bad cycles, want 0", busy_bad); end
    checks++; if (bank_bad != 0) begin errors++; $display("FAIL default_bank: %0d bad cycles, want 0", bank_bad); end
    checks++; if (cyc[100] !== W'(5000) || duty[100] !== '0 || phase[100] !== '0) begin
      errors++; $display("FAIL default_ch100: got %0d/%0d/%0d want 5000/0/0", cyc[100], duty[100], phase[100]);
    end
  endtask

  task automatic test_clamp_wrap();
    do_write(0, 0, 5000); do_write(0, 1, 2500); do_write(0, 2, 1000);
    do_write(248, 0, 4000); do_write(248, 1, 4500); do_write(248, 2, 4000);
    run_update(255, -1, 0, 0, 0, -1, -1);
    checks++; if (cyc[0] !== W'(5000) || duty[0] !== W'(2500) || phase[0] !== W'(1000)) begin
      errors++; $display("FAIL clamp_ch0: got %0d/%0d/%0d want 5000/2500/1000", cyc[0], duty[0], phase[0]);
    end
    checks++; if (cyc[248] !== W'(4000) || duty[248] !== W'(4000) || phase[248] !== W'(0)) begin
      errors++; $display("FAIL clamp_ch248: got %0d/%0d/%0d want 4000/4000/0", cyc[248], duty[248], phase[248]);
    end
    checks++; if (bank_bad != 0) begin errors++; $display("FAIL clamp_bank: %0d bad cycles, want 0", bank_bad); end
  endtask

  task automatic test_mod_scaling();
    do_write(5, 0, 5000); do_write(5, 1, 2500);
    do_write(7, 0, 0); do_write(7, 1, 100); do_write(7, 2, 50);
    run_update(127, -1, 0, 0, 0, -1, -1);
    checks++; if (duty[5] !== W'(1250)) begin errors++; $display("FAIL mod127_duty: got %0d want 1250", duty[5]); end
    checks++; if (duty[7] !== '0 || phase[7] !== '0) begin
      errors++; $display("FAIL zero_cycle: got duty %0d phase %0d want 0/0", duty[7], phase[7]);
    end
    run_update(0, -1, 0, 0, 0, -1, -1);
    checks++; if (duty[5] !== W'(9)) begin errors++; $display("FAIL mod0_duty: got %0d want 9", duty[5]); end
    checks++; if (bank_bad != 0) begin errors++; $display("FAIL mod_bank: %0d bad cycles, want 0", bank_bad); end
  endtask

  task automatic test_ignored_writes();
    do_write(250, 0, 123);
    do_write(9, 3, 77);
    run_update(255, -1, 0, 0, 0, -1, -1);
    checks++; if (cyc[9] !== W'(5000) || duty[9] !== '0 || phase[9] !== '0) begin
      errors++; $display("FAIL ignored_ch9: got %0d/%0d/%0d want 5000/0/0", cyc[9], duty[9], phase[9]);
    end
    checks++; if (bank_bad != 0) begin errors++; $display("FAIL ignored_bank: %0d bad cycles, want 0", bank_bad); end
  endtask

  task automatic test_scan_writes();
    do_write(200, 0, 5000); do_write(200, 1, 100);
    do_write(3, 0, 5000); do_write(3, 1, 200);
    run_update(255, -1, 0, 0, 0, -1, -1);
    run_update(255, 10, 200, 1, 3000, -1, -1);
    checks++; if (duty[200] !== W'(3000)) begin errors++; $display("FAIL scan_late_ch: got %0d want 3000", duty[200]); end
    checks++; if (bank_bad != 0) begin errors++; $display("FAIL scan_late_bank: %0d bad cycles, want 0", bank_bad); end
    run_update(255, 10, 3, 1, 1500, -1, -1);
    checks++; if (duty[3] !== W'(200)) begin errors++; $display("FAIL scan_early_old: got %0d want 200", duty[3]); end
    checks++; if (bank_bad != 0) begin errors++; $display("FAIL scan_early_bank: %0d bad cycles, want 0", bank_bad); end
    run_update(255, -1, 0, 0, 0, -1, -1);
    checks++; if (duty[3] !== W'(1500)) begin errors++; $display("FAIL scan_early_next: got %0d want 1500", duty[3]); end
  endtask

  task automatic test_missed();
    do_reset();
    run_update(255, -1, 0, 0, 0, N + 3, -1);
    checks++; if (missed !== 1'b1) begin errors++; $display("FAIL missed_commit_edge: got %b want 1", missed); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL missed_commit_busy: %0d bad cycles, want 0", busy_bad); end
    do_reset();
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL missed_cleared: got %b want 0", missed); end
    do_write(20, 1, 600);
    run_update(255, -1, 0, 0, 0, 50, -1);
    checks++; if (ov_count != 1) begin errors++; $display("FAIL missed_ov_count: got %0d want 1", ov_count); end
    checks++; if (bank_bad != 0) begin errors++; $display("FAIL missed_bank: %0d bad cycles, want 0", bank_bad); end
    repeat (5) tick();
    checks++; if (missed !== 1'b1) begin errors++; $display("FAIL missed_sticky: got %b want 1", missed); end
  endtask

  task automatic test_reset_mid_scan();
    do_write(0, 0, 3000); do_write(0, 1, 1000); do_write(0, 2, 500);
    run_update(255, -1, 0, 0, 0, -1, -1);
    checks++; if (duty[0] !== W'(1000)) begin errors++; $display("FAIL pre_reset_commit: got %0d want 1000", duty[0]); end
    run_update(200, -1, 0, 0, 0, -1, 100);
    checks++; if (rst_mm != 0) begin errors++; $display("FAIL midreset_bank: %0d channels differ, want 0", rst_mm); end
    checks++; if (cyc[0] !== W'(5000) || duty[0] !== '0) begin
      errors++; $display("FAIL midreset_ch0: got %0d/%0d want 5000/0", cyc[0], duty[0]);
    end
    checks++; if (ov_count != 0) begin errors++; $display("FAIL midreset_ov: got %0d want 0", ov_count); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL midreset_busy: %0d bad cycles, want 0", busy_bad); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 30; w++)
        do_write(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 8191)));
      run_update(int'($urandom_range(0, 255)), int'($urandom_range(1, N + 3)), int'($urandom_range(0, N - 1)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 8191)), -1, -1);
      checks++; if (bank_bad != 0) begin errors++; $display("FAIL random_bank[%0d]: %0d bad cycles, want 0", r, bank_bad); end
      checks++; if (ov_count != 1) begin errors++; $display("FAIL random_ov[%0d]: got %0d want 1", r, ov_count); end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; upd = 1'b0; addr = '0; sel = '0; wdata = '0; mod = '0;
    repeat (2) tick();
    test_reset();
    test_default_update();
    test_clamp_wrap();
    test_mod_scaling();
    test_ignored_writes();
    test_scan_writes();
    test_missed();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
